pipe_skid_register: RTL

- Flow-controlled pipeline stage register; the receiving end of an inter-stage data transfer.
- Accepts a word from the upstream stage with a valid/ready handshake. Presents it to the downstream stage with its own valid/ready handshake.
- Holds up to two words (main + skid), so the upstream ready is fully registered and back-pressure never creates a combinational path across the stage.
- Sits between pipeline stages wherever a stage can stall; also counts downstream stall cycles for performance debug.

---
 rtl/pipe_skid_register.sv | 109 ++++++++++
 1 files changed

// File: rtl/pipe_skid_register.sv
// Flow-controlled two-entry pipeline stage (main + skid register).
// In_ready and Out_valid are both registered from the next state, so
// back-pressure never forms a combinational path across the stage.
// A saturating counter records cycles where a held word is stalled
// by the downstream stage.
module pipe_skid_register #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic                  Flush,
    input  logic                  In_valid,
    output logic                  In_ready,
    input  logic [DATA_WIDTH-1:0] Data_in,
    output logic                  Out_valid,
    input  logic                  Out_ready,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic [CNT_WIDTH-1:0]  Stall_cnt
);

    // Occupancy: number of words currently held.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic [CNT_WIDTH-1:0]  stall_q;
    logic                  in_fire;
    logic                  out_fire;

    assign in_fire  = In_valid & in_ready_q;
    assign out_fire = out_valid_q & Out_ready;

    // Next-state and data steering; flush overrides every transition and
    // leaves the data registers holding stale (masked) contents.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    main_d  = Data_in;
                end
            end
            ONE: begin
                case ({in_fire, out_fire})
                    2'b11: main_d = Data_in;
                    2'b01: state_d = EMPTY;
                    2'b10: begin
                        state_d = TWO;
                        skid_d  = Data_in;
                    end
                    default: ;
                endcase
            end
            TWO: begin
                if (out_fire) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (Flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    // State, data and registered handshake flags decoded from next state.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != TWO);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    // Saturating downstream-stall counter; only reset clears it.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            stall_q <= '0;
        end else if (out_valid_q && !Out_ready && !(&stall_q)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign In_ready  = in_ready_q;
    assign Out_valid = out_valid_q;
    assign Data_out  = main_q;
    assign Stall_cnt = stall_q;

endmodule
